// File: rtl/bus_select_decoder.sv
// Registered 5-to-32 source-select decoder for the internal CPU bus.
// Break-before-make: every change of driving source passes through GAP_CYCLES dead cycles.
module bus_select_decoder #(
    parameter int unsigned N_SRC      = 24,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  sel_code,
    input  logic        sel_valid,
    output logic        sel_ready,
    output logic [31:0] sel_onehot,
    output logic        bus_busy,
    output logic        sel_err
);

    localparam int unsigned CODE_W = 5;
    localparam int unsigned OH_W   = 32;
    localparam int unsigned CNT_W  = 3;

    localparam logic [CODE_W-1:0] CODE_RELEASE = 5'd31;
    localparam logic [CNT_W-1:0]  GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GAP   = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [OH_W-1:0]   onehot_q,  onehot_d;
    logic              err_q,     err_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [CODE_W-1:0] cur_q,     cur_d;
    logic [CODE_W-1:0] pend_q,    pend_d;

    logic accept_c;
    logic is_legal_c;
    logic is_release_c;
    logic is_illegal_c;

    // Handshake and code classification
    assign sel_ready    = (state_q != ST_GAP);
    assign bus_busy     = (state_q != ST_IDLE);
    assign accept_c     = sel_valid & sel_ready;
    assign is_release_c = (sel_code == CODE_RELEASE);
    assign is_legal_c   = (32'(sel_code) < N_SRC) && !is_release_c;
    assign is_illegal_c = !is_legal_c && !is_release_c;

    assign sel_onehot = onehot_q;
    assign sel_err    = err_q;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            onehot_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            cur_q    <= CODE_RELEASE;
            pend_q   <= CODE_RELEASE;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        pend_d   = pend_q;

        case (state_q)
            ST_IDLE: begin
                // Nothing is driving, so a legal code enables immediately
                if (accept_c) begin
                    if (is_legal_c) begin
                        state_d  = ST_DRIVE;
                        onehot_d = OH_W'(1) << sel_code;
                        cur_d    = sel_code;
                    end else if (is_illegal_c) begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_DRIVE: begin
                if (accept_c) begin
                    if (is_release_c) begin
                        state_d  = ST_IDLE;
                        onehot_d = '0;
                        cur_d    = CODE_RELEASE;
                    end else if (is_illegal_c) begin
                        err_d = 1'b1;
                    end else if (sel_code != cur_q) begin
                        state_d  = ST_GAP;
                        onehot_d = '0;
                        pend_d   = sel_code;
                        cnt_d    = GAP_LOAD;
                    end
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d  = ST_DRIVE;
                    onehot_d = OH_W'(1) << pend_q;
                    cur_d    = pend_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                onehot_d = '0;
                cur_d    = CODE_RELEASE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_select_decoder.sv
// Directed bench for bus_select_decoder: one instance with a 1-cycle gap, one with a 3-cycle gap.
module tb_bus_select_decoder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [4:0]  code_a, code_b;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic [31:0] onehot_a, onehot_b;
    logic        busy_a, busy_b;
    logic        err_a, err_b;

    int checks   = 0;
    int failures = 0;
    int run_len [2];

    always #5 clk = ~clk;

    bus_select_decoder #(.N_SRC(24), .GAP_CYCLES(1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_code   (code_a),
        .sel_valid  (valid_a),
        .sel_ready  (ready_a),
        .sel_onehot (onehot_a),
        .bus_busy   (busy_a),
        .sel_err    (err_a)
    );

    bus_select_decoder #(.N_SRC(24), .GAP_CYCLES(3)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_code   (code_b),
        .sel_valid  (valid_b),
        .sel_ready  (ready_b),
        .sel_onehot (onehot_b),
        .bus_busy   (busy_b),
        .sel_err    (err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle soak checks: at most one bit, no bits above the last legal source, exact gap length
    task automatic soak_chk(input int idx, input logic [31:0] oh, input logic busy, input int gap);
        chk("soak_onehot0", 32'($onehot0(oh)), 32'd1);
        chk("soak_hi_bits", oh & 32'hFF00_0000, 32'h0);
        if (busy && oh == 32'h0) begin
            run_len[idx]++;
        end else if (oh != 32'h0) begin
            if (run_len[idx] > 0) chk("soak_gap_len", 32'(run_len[idx]), 32'(gap));
            run_len[idx] = 0;
        end else begin
            run_len[idx] = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b1;
        code_a  = 5'd0;  valid_a = 1'b0;
        code_b  = 5'd0;  valid_b = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_onehot", onehot_a, 32'h0);
        chk("rst_busy",   32'(busy_a), 32'd0);
        chk("rst_ready",  32'(ready_a), 32'd1);
        chk("rst_err",    32'(err_a), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Idle -> drive source 5 with one cycle of latency
        code_a = 5'd5; valid_a = 1'b1;
        step(); valid_a = 1'b0;
        chk("idle_to_5", onehot_a, 32'h0000_0020);
        chk("idle_to_5_busy", 32'(busy_a), 32'd1);

        // Switch 5 -> 9 with a single dead cycle
        code_a = 5'd9; valid_a = 1'b1;
        step(); valid_a = 1'b0;
        chk("gap1_zero", onehot_a, 32'h0);
        chk("gap1_ready", 32'(ready_a), 32'd0);
        step();
        chk("gap1_new", onehot_a, 32'h0000_0200);
        chk("gap1_ready_back", 32'(ready_a), 32'd1);

        // Same code held valid must never glitch the enable
        code_a = 5'd9; valid_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("same_code_hold", onehot_a, 32'h0000_0200);
        end
        valid_a = 1'b0;

        // Move to source 3, then offer illegal codes
        code_a = 5'd3; valid_a = 1'b1;
        step(); valid_a = 1'b0;
        step();
        chk("to_3", onehot_a, 32'h0000_0008);
        code_a = 5'd24; valid_a = 1'b1;
        step(); valid_a = 1'b0;
        chk("illegal24_err", 32'(err_a), 32'd1);
        chk("illegal24_hold", onehot_a, 32'h0000_0008);
        step();
        chk("illegal24_err_drop", 32'(err_a), 32'd0);
        chk("illegal24_hold2", onehot_a, 32'h0000_0008);
        code_a = 5'd30; valid_a = 1'b1;
        step(); valid_a = 1'b0;
        chk("illegal30_err", 32'(err_a), 32'd1);
        chk("illegal30_busy", 32'(busy_a), 32'd1);

        // Release, then re-acquire with no gap
        code_a = 5'd31; valid_a = 1'b1;
        step(); valid_a = 1'b0;
        chk("release_onehot", onehot_a, 32'h0);
        chk("release_busy", 32'(busy_a), 32'd0);
        code_a = 5'd0; valid_a = 1'b1;
        step(); valid_a = 1'b0;
        chk("reacquire_0", onehot_a, 32'h0000_0001);
        chk("reacquire_busy", 32'(busy_a), 32'd1);

        // Release in idle is a no-op; illegal in idle pulses err only
        code_a = 5'd31; valid_a = 1'b1;
        step(); step(); valid_a = 1'b0;
        chk("idle_release_busy", 32'(busy_a), 32'd0);
        chk("idle_release_err", 32'(err_a), 32'd0);
        code_a = 5'd25; valid_a = 1'b1;
        step(); valid_a = 1'b0;
        chk("idle_illegal_err", 32'(err_a), 32'd1);
        chk("idle_illegal_onehot", onehot_a, 32'h0);

        // Three-cycle gap on the second instance; producer holds the code through the gap
        code_b = 5'd5; valid_b = 1'b1;
        step();
        chk("b_to_5", onehot_b, 32'h0000_0020);
        code_b = 5'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap3_zero", onehot_b, 32'h0);
            chk("gap3_ready", 32'(ready_b), 32'd0);
        end
        step();
        chk("gap3_new", onehot_b, 32'h0000_0200);
        step();
        chk("gap3_held_same", onehot_b, 32'h0000_0200);
        valid_b = 1'b0;

        // Reset asserted mid-gap takes effect immediately
        code_b = 5'd7; valid_b = 1'b1;
        step(); valid_b = 1'b0;
        step();
        chk("midgap_pre", 32'(ready_b), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midgap_rst_onehot", onehot_b, 32'h0);
        chk("midgap_rst_busy", 32'(busy_b), 32'd0);
        chk("midgap_rst_ready", 32'(ready_b), 32'd1);
        chk("middrive_rst_onehot", onehot_a, 32'h0);
        step();
        rst_n = 1'b1;

        // Random soak on both instances
        run_len[0] = 0;
        run_len[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            code_a  = 5'($urandom_range(0, 31));
            valid_a = 1'($urandom_range(0, 1));
            code_b  = 5'($urandom_range(0, 31));
            valid_b = 1'($urandom_range(0, 1));
            step();
            soak_chk(0, onehot_a, busy_a, 1);
            soak_chk(1, onehot_b, busy_b, 3);
        end
        valid_a = 1'b0;
        valid_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
